int_ctrl: RTL
=============

INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port ext_int_i, input, 5 bits: raw external interrupt lines, asynchronous to clk.
REQ-004 SHALL have port cfg_we, input, 1 bit: configuration write strobe, from the WB-stage MTC0 path.
REQ-005 SHALL have port cfg_addr, input, 3 bits: register select for both read and write.
REQ-006 SHALL have port cfg_wdata, input, 32 bits: write data.
REQ-007 SHALL have port cfg_rdata, output, 32 bits: combinational read data for cfg_addr.
REQ-008 SHALL have port int_o, output, 8 bits: interrupt request vector to the CP0 int_i input; bits [7:6] SHALL be tied to 0.

Function
REQ-009 SHALL decode the register map as: 0 MODE[4:0] (1=edge, 0=level per line); 1 MASK[5:0]; 2 PEND[5:0] (write-1-to-clear); 3 COMPARE[31:0]; 4 COUNT[31:0].
REQ-010 SHALL read unmapped addresses (5-7) and unused upper bits as 0; writes to them SHALL have no effect.
REQ-011 SHALL pass each ext_int_i line through a 2-flop synchronizer (s1, s2) plus a history flop s3.
REQ-012 SHALL, for an edge-mode line i, set PEND[i] on the clock after s2 & ~s3 is true; the bit stays set until cleared.
REQ-013 SHALL, for a level-mode line i, load PEND[i] from s2 every cycle; W1C writes to that bit SHALL be ignored.
REQ-014 SHALL give the following fixed latency: a line rising and sampled at edge k sets PEND at edge k+2, and int_o reflects it after edge k+3.
REQ-015 SHALL make int_o[5:0] a register loaded each cycle with PEND[5:0] & MASK[5:0].
REQ-016 SHALL let a new edge-detect or timer set win over a W1C of the same bit in the same cycle.
REQ-017 SHALL, on a MODE write, clear PEND[i] for every line i whose mode bit changes.
REQ-018 SHALL run a divide-by-2 toggle (div) and increment COUNT on cycles where div=1; COUNT SHALL wrap 0xFFFFFFFF -> 0.
REQ-019 SHALL let a COUNT write in a cycle take precedence over the increment in that cycle.
REQ-020 SHALL set PEND[5] (timer, maps to IP7) in any cycle where COUNT == COMPARE.
REQ-021 SHALL clear PEND[5] on a COMPARE write, unless a match with the new COMPARE value occurs in the same cycle, in which case the set wins.
REQ-022 SHALL also clear PEND[5] by W1C at address 2.
REQ-023 SHALL update only the addressed register on a write; PEND[4:0] SHALL be cleared by W1C for edge-mode lines only.

Reset
REQ-024 SHALL, while rst_=0, asynchronously force the following values: s1/s2/s3=0, div=0, MODE=0, MASK=0, PEND=0, COUNT=0, COMPARE=32'hFFFF_FFFF, int_o=8'h00.
REQ-025 SHALL hold cfg_rdata = 0 while rst_=0.
REQ-026 SHALL, on reset assertion mid-operation, drop pending requests and int_o within the same cycle, without waiting for a clock edge.

Verification
REQ-027 SHALL cover level mode: MASK=0x01, ext_int_i[0] held 1 -> int_o=8'h01 three edges after sampling; release -> int_o=0 three edges later; W1C PEND=0x01 while held -> no change.
REQ-028 SHALL cover edge mode: MODE=0x02, MASK=0x02, 1-cycle pulse on ext_int_i[1] -> int_o=8'h02 and sticky; W1C 0x02 -> int_o=0 two edges after the write.
REQ-029 SHALL cover the timer: COMPARE=10, MASK=0x20, COUNT=0 -> PEND[5] sets when COUNT reaches 10 (~20 clocks); COMPARE write of 100 -> int_o[5] clears.
REQ-030 SHALL cover set/clear collision: edge-mode detect on line 2 in the same cycle as W1C 0x04 -> PEND[2] remains 1.
REQ-031 SHALL cover wrap and mask: COUNT=0xFFFFFFFF, COMPARE=0 -> match after wrap with PEND[5]=1; MASK=0 -> int_o stays 0; readback of address 2 = 0x20.
REQ-032 SHALL cover async reset: assert rst_ between edges with int_o=0x21 -> int_o=0 immediately; after release all registers read their reset values.

Source files
------------

// File: rtl/int_ctrl.sv
`timescale 1ns/1ps
// int_ctrl -- external interrupt and timer controller feeding the CP0 int_i input.
//
// Five external lines are synchronised, then latched into PEND either as
// level (PEND follows the synchronised line) or as sticky rising edges
// (cleared by write-1-to-clear). A free-running COUNT, advancing every second
// clock, raises PEND[5] whenever it equals COMPARE. int_o is the registered
// masked pending vector.
//
// Ports:
//   clk        in   1  clock, all state updates on the rising edge
//   rst_       in   1  asynchronous active-low reset
//   ext_int_i  in   5  raw external interrupt lines (asynchronous to clk)
//   cfg_we     in   1  configuration write strobe
//   cfg_addr   in   3  register select: 0 MODE, 1 MASK, 2 PEND, 3 COMPARE, 4 COUNT
//   cfg_wdata  in  32  write data
//   cfg_rdata  out 32  combinational read data for cfg_addr (0 while in reset)
//   int_o      out  8  interrupt request vector, bits [7:6] always 0
module int_ctrl (
  input  logic        clk,
  input  logic        rst_,
  input  logic [4:0]  ext_int_i,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic [31:0] cfg_rdata,
  output logic [7:0]  int_o
);

  localparam logic [2:0] ADDR_MODE    = 3'd0;
  localparam logic [2:0] ADDR_MASK    = 3'd1;
  localparam logic [2:0] ADDR_PEND    = 3'd2;
  localparam logic [2:0] ADDR_COMPARE = 3'd3;
  localparam logic [2:0] ADDR_COUNT   = 3'd4;

  // Synchroniser chain plus history flop for edge detection.
  logic [4:0]  s1_q, s2_q, s3_q;
  logic        div_q, div_d;
  logic [4:0]  mode_q, mode_d;
  logic [5:0]  mask_q, mask_d;
  logic [5:0]  pend_q, pend_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic [5:0]  irq_q, irq_d;

  logic        mode_we, mask_we, pend_we, compare_we, count_we;
  logic [4:0]  edge_det;
  logic [4:0]  mode_chg;
  logic [5:0]  w1c;
  logic [4:0]  line_pend_d;
  logic [31:0] compare_eff;
  logic        timer_match;
  logic        timer_pend_d;

  assign mode_we    = cfg_we && (cfg_addr == ADDR_MODE);
  assign mask_we    = cfg_we && (cfg_addr == ADDR_MASK);
  assign pend_we    = cfg_we && (cfg_addr == ADDR_PEND);
  assign compare_we = cfg_we && (cfg_addr == ADDR_COMPARE);
  assign count_we   = cfg_we && (cfg_addr == ADDR_COUNT);

  assign edge_det = s2_q & ~s3_q;
  assign w1c      = pend_we ? cfg_wdata[5:0] : 6'd0;

  // Per-line pending logic. A mode change always clears the bit; level lines
  // simply follow the synchronised input (W1C has no effect); edge lines are
  // sticky and a fresh edge beats a simultaneous W1C.
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_line
      assign mode_chg[gi]    = mode_we && (cfg_wdata[gi] != mode_q[gi]);
      assign line_pend_d[gi] = mode_chg[gi] ? 1'b0 :
                               mode_q[gi]   ? (edge_det[gi] | (pend_q[gi] & ~w1c[gi])) :
                                              s2_q[gi];
    end
  endgenerate

  // The match is evaluated against the COMPARE value being written this cycle,
  // so a write that creates an immediate match keeps PEND[5] set.
  assign compare_eff  = compare_we ? cfg_wdata : compare_q;
  assign timer_match  = (count_q == compare_eff);
  assign timer_pend_d = timer_match | (pend_q[5] & ~w1c[5] & ~compare_we);

  always_comb begin
    div_d     = ~div_q;
    mode_d    = mode_we    ? cfg_wdata[4:0] : mode_q;
    mask_d    = mask_we    ? cfg_wdata[5:0] : mask_q;
    compare_d = compare_we ? cfg_wdata      : compare_q;
    // A software COUNT write overrides the increment of the same cycle.
    if (count_we) begin
      count_d = cfg_wdata;
    end else if (div_q) begin
      count_d = count_q + 32'd1;
    end else begin
      count_d = count_q;
    end
    pend_d = {timer_pend_d, line_pend_d};
    irq_d  = pend_q & mask_q;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      s1_q      <= 5'd0;
      s2_q      <= 5'd0;
      s3_q      <= 5'd0;
      div_q     <= 1'b0;
      mode_q    <= 5'd0;
      mask_q    <= 6'd0;
      pend_q    <= 6'd0;
      count_q   <= 32'd0;
      compare_q <= 32'hFFFF_FFFF;
      irq_q     <= 6'd0;
    end else begin
      s1_q      <= ext_int_i;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      div_q     <= div_d;
      mode_q    <= mode_d;
      mask_q    <= mask_d;
      pend_q    <= pend_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      irq_q     <= irq_d;
    end
  end

  // Read mux; forced to zero while reset is asserted.
  always_comb begin
    cfg_rdata = 32'd0;
    case (cfg_addr)
      ADDR_MODE:    cfg_rdata = {27'd0, mode_q};
      ADDR_MASK:    cfg_rdata = {26'd0, mask_q};
      ADDR_PEND:    cfg_rdata = {26'd0, pend_q};
      ADDR_COMPARE: cfg_rdata = compare_q;
      ADDR_COUNT:   cfg_rdata = count_q;
      default:      cfg_rdata = 32'd0;
    endcase
    if (!rst_) begin
      cfg_rdata = 32'd0;
    end
  end

  assign int_o = {2'b00, irq_q};

endmodule
